// File: rtl/instr_stream_decoder.sv
// Halfword FIFO feeding a 16/32-bit instruction decoder whose FSM only advances on a divided-rate tick.
// Latency: out_valid rises the cycle after the popping tick; in_ready is registered !full and results hold until out_ready.

module isd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             ready
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  // flush outranks both ends so a dropped halfword can never slip in the same cycle
  assign do_push = push && ready && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      ready <= (count_next != CNT_W'(DEPTH));
    end
  end
endmodule

module instr_stream_decoder #(
  parameter int DIV_COUNT  = 217,
  parameter int DIV_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_long,
  output logic [1:0]  out_class,
  output logic [7:0]  out_opcode,
  output logic [5:0]  out_rd,
  output logic [5:0]  out_ra,
  output logic [5:0]  out_rb,
  output logic        tick
);
  typedef enum logic {S_FIRST, S_SECOND} state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [15:0]      head;
  logic [14:0]      first_hw;
  logic             fifo_empty;
  logic             pop;
  logic             latch_first;
  logic             load_short;
  logic             load_long;
  logic             slot_free;

  always_comb begin
    div_next = (div_cnt == DIV_W'(DIV_COUNT)) ? '0 : div_cnt + 1'b1;
  end

  // tick is registered so it is high exactly while div_cnt sits at DIV_COUNT
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      tick    <= (div_next == DIV_W'(DIV_COUNT));
    end
  end

  isd_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst   (reset),
    .flush (flush),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .ready (in_ready)
  );

  assign slot_free = !out_valid || out_ready;

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    latch_first = 1'b0;
    load_short  = 1'b0;
    load_long   = 1'b0;
    if (tick && !flush && !fifo_empty && slot_free) begin
      pop = 1'b1;
      case (state)
        S_FIRST: begin
          if (head[15]) begin
            latch_first = 1'b1;
            state_next  = S_SECOND;
          end else begin
            load_short = 1'b1;
          end
        end
        S_SECOND: begin
          load_long  = 1'b1;
          state_next = S_FIRST;
        end
        default: state_next = S_FIRST;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= S_FIRST;
      first_hw <= '0;
    end else if (flush) begin
      state <= S_FIRST;
    end else begin
      state <= state_next;
      if (latch_first) begin
        first_hw <= head[14:0];
      end
    end
  end

  // a new load in the handshake cycle wins over clearing out_valid
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_long   <= 1'b0;
      out_class  <= '0;
      out_opcode <= '0;
      out_rd     <= '0;
      out_ra     <= '0;
      out_rb     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_short) begin
      out_valid  <= 1'b1;
      out_long   <= 1'b0;
      out_class  <= head[14:13];
      out_opcode <= {4'b0, head[12:9]};
      out_rd     <= {3'b0, head[8:6]};
      out_ra     <= {3'b0, head[5:3]};
      out_rb     <= {3'b0, head[2:0]};
    end else if (load_long) begin
      out_valid  <= 1'b1;
      out_long   <= 1'b1;
      out_class  <= first_hw[14:13];
      out_opcode <= {head[12:9], first_hw[12:9]};
      out_rd     <= {head[8:6], first_hw[8:6]};
      out_ra     <= {head[5:3], first_hw[5:3]};
      out_rb     <= {head[2:0], first_hw[2:0]};
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instr_stream_decoder.sv
// Directed bench for instr_stream_decoder with DIV_COUNT=3 (tick every 4th cycle), FIFO depth 4.
module tb_instr_stream_decoder;
  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_long, tick;
  logic [1:0]  out_class;
  logic [7:0]  out_opcode;
  logic [5:0]  out_rd, out_ra, out_rb;

  int checks = 0;
  int fails = 0;

  instr_stream_decoder #(.DIV_COUNT(3), .DIV_W(4), .FIFO_DEPTH(4)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_long(out_long),
    .out_class(out_class), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_ra(out_ra), .out_rb(out_rb), .tick(tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, required to finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (tick) return;
    end
    checks++; fails++;
    $display("FAIL wait_tick: tick stayed 0 for 20 cycles, required a tick every 4");
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLOCK_50);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if ({out_long, out_class, out_opcode, out_rd, out_ra, out_rb} !== 29'h0) begin
      fails++; $display("FAIL reset_fields: got %h want 0", {out_long, out_class, out_opcode, out_rd, out_ra, out_rb});
    end
  endtask

  task automatic test_divider();
    int ticks[$];
    reset = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLOCK_50);
      if (tick) ticks.push_back(c + 1);
    end
    checks++; if (ticks.size() !== 4) begin fails++; $display("FAIL div_count: got %0d ticks want 4", ticks.size()); end
    if (ticks.size() >= 4) begin
      checks++; if (ticks[0] !== 4) begin fails++; $display("FAIL div_first: got cycle %0d want 4", ticks[0]); end
      checks++; if (ticks[1] - ticks[0] !== 4) begin fails++; $display("FAIL div_period: got %0d want 4", ticks[1] - ticks[0]); end
      checks++; if (ticks[3] - ticks[2] !== 4) begin fails++; $display("FAIL div_period2: got %0d want 4", ticks[3] - ticks[2]); end
    end
  endtask

  task automatic test_short();
    int tick_k = 0, got_k = 0, nv = 0;
    logic [28:0] f = '0;
    out_ready = 1'b1;
    wait_tick();
    in_valid = 1'b1; in_data = 16'h1A5B;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLOCK_50);
      if (k == 1) in_valid = 1'b0;
      if (tick && tick_k == 0) tick_k = k;
      if (out_valid) begin
        nv++;
        if (got_k == 0) begin got_k = k; f = {out_long, out_class, out_opcode, out_rd, out_ra, out_rb}; end
      end
    end
    checks++; if (tick_k !== 4) begin fails++; $display("FAIL short_tick: got k=%0d want 4", tick_k); end
    checks++; if (got_k !== 5) begin fails++; $display("FAIL short_latency: got k=%0d want 5", got_k); end
    checks++; if (nv !== 1) begin fails++; $display("FAIL short_count: got %0d want 1", nv); end
    checks++; if (f !== {1'b0, 2'd0, 8'h0D, 6'd1, 6'd3, 6'd3}) begin
      fails++; $display("FAIL short_fields: got long=%b cls=%0d opc=%h rd=%0d ra=%0d rb=%0d want 0 0 0d 1 3 3",
                        f[28], f[27:26], f[25:18], f[17:12], f[11:6], f[5:0]);
    end
  endtask

  task automatic test_long();
    int vk = 0, nv = 0;
    logic [28:0] f = '0;
    out_ready = 1'b1;
    wait_tick();
    in_valid = 1'b1; in_data = 16'hA249;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLOCK_50);
      if (out_valid) begin
        nv++;
        if (vk == 0) begin vk = k; f = {out_long, out_class, out_opcode, out_rd, out_ra, out_rb}; end
      end
      if (k == 1) in_data = 16'h1C92;
      if (k == 2) in_valid = 1'b0;
    end
    checks++; if (nv !== 1) begin fails++; $display("FAIL long_count: got %0d want 1", nv); end
    checks++; if (vk !== 9) begin fails++; $display("FAIL long_latency: got k=%0d want 9", vk); end
    checks++; if (f !== {1'b1, 2'd1, 8'hE1, 6'd17, 6'd17, 6'd17}) begin
      fails++; $display("FAIL long_fields: got long=%b cls=%0d opc=%h rd=%0d ra=%0d rb=%0d want 1 1 e1 17 17 17",
                        f[28], f[27:26], f[25:18], f[17:12], f[11:6], f[5:0]);
    end
  endtask

  task automatic test_backpressure();
    int changes = 0;
    int ops[$];
    int ks[$];
    out_ready = 1'b0;
    wait_tick();
    in_valid = 1'b1; in_data = 16'h0201;
    @(negedge CLOCK_50); in_data = 16'h0402;
    @(negedge CLOCK_50); in_data = 16'h0603;
    @(negedge CLOCK_50); in_data = 16'h0804;
    @(negedge CLOCK_50);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full: in_ready got %b want 0", in_ready); end
    in_data = 16'h0A05;
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_after_pop: in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_opcode !== 8'h01) begin
      fails++; $display("FAIL bp_first: got valid=%b opc=%h want 1 01", out_valid, out_opcode);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge CLOCK_50);
      if (!out_valid || out_opcode !== 8'h01 || out_rb !== 6'd1) changes++;
    end
    checks++; if (changes !== 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles want 0", changes); end
    out_ready = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLOCK_50);
      if (out_valid) begin ops.push_back(int'(out_opcode)); ks.push_back(k); end
    end
    checks++; if (ops.size() !== 3) begin fails++; $display("FAIL bp_drain_count: got %0d want 3", ops.size()); end
    if (ops.size() >= 3) begin
      checks++; if (ops[0] !== 2 || ops[1] !== 3 || ops[2] !== 4) begin
        fails++; $display("FAIL bp_drain_order: got %0d %0d %0d want 2 3 4", ops[0], ops[1], ops[2]);
      end
      checks++; if (ks[1] - ks[0] !== 4 || ks[2] - ks[1] !== 4) begin
        fails++; $display("FAIL bp_drain_rate: got gaps %0d %0d want 4 4", ks[1] - ks[0], ks[2] - ks[1]);
      end
    end
  endtask

  task automatic test_flush();
    int vk = 0, nv = 0;
    logic [28:0] f = '0;
    out_ready = 1'b1;
    wait_tick();
    in_valid = 1'b1; in_data = 16'hA249;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLOCK_50);
      if (out_valid) begin
        nv++;
        if (vk == 0) begin vk = k; f = {out_long, out_class, out_opcode, out_rd, out_ra, out_rb}; end
      end
      if (k == 1) in_valid = 1'b0;
      if (k == 5) begin flush = 1'b1; in_valid = 1'b1; in_data = 16'h0201; end
      if (k == 6) begin
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        flush = 1'b0; in_data = 16'h1A5B;
      end
      if (k == 7) in_valid = 1'b0;
    end
    checks++; if (nv !== 1) begin fails++; $display("FAIL flush_count: got %0d outputs want 1", nv); end
    checks++; if (vk !== 9) begin fails++; $display("FAIL flush_latency: got k=%0d want 9", vk); end
    checks++; if (f !== {1'b0, 2'd0, 8'h0D, 6'd1, 6'd3, 6'd3}) begin
      fails++; $display("FAIL flush_fields: got long=%b opc=%h rd=%0d want 0 0d 1", f[28], f[25:18], f[17:12]);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    logic [28:0] f = '0;
    out_ready = 1'b0;
    wait_tick();
    in_valid = 1'b1; in_data = 16'h1A5B;
    @(negedge CLOCK_50); in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK_50);
      if (out_valid) break;
    end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || tick !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_async_ctrl: got valid=%b tick=%b in_ready=%b want 0 0 1", out_valid, tick, in_ready);
    end
    checks++; if ({out_long, out_class, out_opcode, out_rd, out_ra, out_rb} !== 29'h0) begin
      fails++; $display("FAIL rst_async_fields: got %h want 0", {out_long, out_class, out_opcode, out_rd, out_ra, out_rb});
    end
    @(negedge CLOCK_50); reset = 1'b0;
    out_ready = 1'b1;
    wait_tick();
    in_valid = 1'b1; in_data = 16'hA249;
    @(negedge CLOCK_50); in_valid = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50); reset = 1'b0;
    wait_tick();
    in_valid = 1'b1; in_data = 16'h1C92;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLOCK_50);
      if (k == 1) in_valid = 1'b0;
      if (out_valid) begin
        nv++;
        f = {out_long, out_class, out_opcode, out_rd, out_ra, out_rb};
      end
    end
    checks++; if (nv !== 1) begin fails++; $display("FAIL rst_mid_count: got %0d want 1", nv); end
    checks++; if (f !== {1'b0, 2'd0, 8'h0E, 6'd2, 6'd2, 6'd2}) begin
      fails++; $display("FAIL rst_mid_fields: got long=%b opc=%h rd=%0d want 0 0e 2", f[28], f[25:18], f[17:12]);
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_short();
    test_long();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
